// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins and rx/tx word handshake of spi_slave (miso_oe under SPI_SLAVE_MISO_OE_EN)
interface spi_slave_if #(
  parameter int DATA_W = 16
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_taken;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_overrun;
  logic              frame_err;
  logic              busy;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic              miso_oe;
`endif

  modport slave (
    input  sclk, cs_n, mosi, tx_data, rx_ack,
    output miso, tx_taken, rx_data, rx_valid, rx_overrun, frame_err, busy
`ifdef SPI_SLAVE_MISO_OE_EN
    , output miso_oe
`endif
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, rx_ack,
    input  miso, tx_taken, rx_data, rx_valid, rx_overrun, frame_err, busy
`ifdef SPI_SLAVE_MISO_OE_EN
    , input miso_oe
`endif
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling mode-0 SPI slave; optional miso_oe port via SPI_SLAVE_MISO_OE_EN
module spi_slave #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sclk_pipe, cs_pipe, mosi_pipe, fill;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, armed;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [DATA_W-1:0] tx_shift, rx_shift, rx_data_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rx_valid_q, rx_overrun_q, tx_taken_q, frame_err_q;

  logic start, rx_en, tx_en, tx_clr, end_ok, end_bad;

  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  // A fall only counts once a real high level of cs_n has been seen after reset,
  // so a frame already running when reset lifts is skipped entirely.
  assign cs_fall   = armed & cs_d & ~cs_s;

  // Synchronisers plus one history flop; fill tracks when real samples reach the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      fill      <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], bus.sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], bus.cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and datapath strobes; cs_n rise takes priority over a coincident sclk edge.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    rx_en   = 1'b0;
    tx_en   = 1'b0;
    tx_clr  = 1'b0;
    end_ok  = 1'b0;
    end_bad = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          tx_clr  = 1'b1;
          if (bit_cnt == CNT_FULL) end_ok  = 1'b1;
          else                     end_bad = 1'b1;
        end else if (sclk_rise) begin
          rx_en = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt < CNT_FULL) tx_en  = 1'b1;
          else                    tx_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter and the rx word handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_taken_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      tx_taken_q  <= start;
      frame_err_q <= end_bad;
      if (start) begin
        tx_shift <= bus.tx_data;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (rx_en) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (tx_en)  tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (tx_clr) tx_shift <= '0;
      if (end_ok) begin
        rx_data_q  <= rx_shift;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !bus.rx_ack) rx_overrun_q <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.miso       = (state == ACTIVE) & tx_shift[DATA_W-1];
  assign bus.busy       = (state == ACTIVE);
  assign bus.tx_taken   = tx_taken_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.frame_err  = frame_err_q;
`ifdef SPI_SLAVE_MISO_OE_EN
  assign bus.miso_oe    = (state == ACTIVE);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - bench for spi_slave: vector table, reset/ack corner cases, random frames vs model
module tb_spi_slave;
  localparam int DW   = 16;
  localparam int SS   = 2;
  localparam int HALF = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(DW)) bus();

  spi_slave #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int taken_cnt = 0;
  int ferr_cnt  = 0;

  always @(negedge clk) begin
    if (bus.tx_taken)  taken_cnt <= taken_cnt + 1;
    if (bus.frame_err) ferr_cnt  <= ferr_cnt + 1;
  end

  typedef struct {
    logic [15:0] tx;
    logic [31:0] word;
    int          nbits;
    bit          ack_before;
    bit          ack_end;
    logic [31:0] e_miso;
    logic [15:0] e_rx;
    bit          e_valid;
    bit          e_ovr;
    bit          e_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    wait_clk(1);
  endtask

  task automatic spi_bit(input logic b, output logic got_bit);
    bus.mosi = b;
    wait_clk(HALF);
    got_bit = bus.miso;
    bus.sclk = 1'b1;
    wait_clk(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] tx, input logic [31:0] word, input int nbits,
                           input bit ack_end, output logic [31:0] got, output logic valid_end,
                           output logic busy_mid, output logic oe_mid);
    logic b;
    got = '0;
    bus.tx_data = tx;
    @(negedge clk);
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    busy_mid = bus.busy;
`ifdef SPI_SLAVE_MISO_OE_EN
    oe_mid = bus.miso_oe;
`else
    oe_mid = 1'b1;
`endif
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(word[i], b);
      got = {got[30:0], b};
    end
    bus.mosi = 1'b0;
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    for (int k = 0; k < SS + 1; k++) begin
      if (ack_end && k == SS) bus.rx_ack = 1'b1;
      @(negedge clk);
    end
    bus.rx_ack = 1'b0;
    valid_end = bus.rx_valid;
    wait_clk(4);
  endtask

  vec_t tbl[9];

  initial begin
    logic [31:0] got, exp_miso;
    logic        v_end, b_mid, oe_mid, b;
    int          t0, f0, nb;
    logic [15:0] tx, m_rx;
    logic [31:0] word;
    bit          ab, ae, m_valid, m_ovr, e_ferr;

    tbl[0] = '{16'hA55A, 32'h1234,  16, 0, 0, 32'hA55A,  16'h1234, 1, 0, 0};
    tbl[1] = '{16'h0F0F, 32'h0001,  16, 1, 0, 32'h0F0F,  16'h0001, 1, 0, 0};
    tbl[2] = '{16'h8001, 32'hFFFF,  16, 1, 0, 32'h8001,  16'hFFFF, 1, 0, 0};
    tbl[3] = '{16'h1234, 32'h00AA,   9, 0, 0, 32'h0024,  16'hFFFF, 1, 0, 1};
    tbl[4] = '{16'hC0DE, 32'hBEEF,  16, 1, 0, 32'hC0DE,  16'hBEEF, 1, 0, 0};
    tbl[5] = '{16'h0000, 32'h0000,   0, 1, 0, 32'h0000,  16'hBEEF, 0, 0, 1};
    tbl[6] = '{16'h7777, 32'h0001,  16, 1, 0, 32'h7777,  16'h0001, 1, 0, 0};
    tbl[7] = '{16'hFFFF, 32'hFFFF,  16, 0, 0, 32'hFFFF,  16'hFFFF, 1, 1, 0};
    tbl[8] = '{16'hAAAA, 32'h11111, 17, 0, 0, 32'h15554, 16'hFFFF, 1, 1, 1};

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.rx_ack = 1'b0; bus.tx_data = '0;
    wait_clk(3);
    check("reset_rx_data", 32'(bus.rx_data), 32'h0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset_overrun", 32'(bus.rx_overrun), 32'h0);
    check("reset_busy_miso", {bus.busy, bus.miso, bus.tx_taken, bus.frame_err}, 32'h0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("reset_miso_oe", 32'(bus.miso_oe), 32'h0);
`endif
    rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].ack_before) pulse_ack();
      t0 = taken_cnt; f0 = ferr_cnt;
      spi_frame(tbl[i].tx, tbl[i].word, tbl[i].nbits, tbl[i].ack_end, got, v_end, b_mid, oe_mid);
      check($sformatf("tbl%0d_miso", i), got, tbl[i].e_miso);
      check($sformatf("tbl%0d_rx_data", i), 32'(bus.rx_data), 32'(tbl[i].e_rx));
      check($sformatf("tbl%0d_valid_end", i), 32'(v_end), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_rx_valid", i), 32'(bus.rx_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_overrun", i), 32'(bus.rx_overrun), 32'(tbl[i].e_ovr));
      check($sformatf("tbl%0d_frame_err", i), 32'(ferr_cnt - f0), 32'(tbl[i].e_ferr));
      check($sformatf("tbl%0d_tx_taken", i), 32'(taken_cnt - t0), 32'd1);
      check($sformatf("tbl%0d_busy", i), {b_mid, oe_mid, bus.busy}, {1'b1, 1'b1, 1'b0});
`ifdef SPI_SLAVE_MISO_OE_EN
      check($sformatf("tbl%0d_miso_oe_idle", i), 32'(bus.miso_oe), 32'h0);
`endif
    end

    // Reset in the middle of a frame, released while cs_n is still low.
    bus.tx_data = 16'h1111;
    @(negedge clk);
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    rst_n = 1'b0;
    #2;
    check("midrst_rx_data", 32'(bus.rx_data), 32'h0);
    check("midrst_flags", {bus.rx_valid, bus.rx_overrun, bus.busy, bus.miso}, 32'h0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("midrst_miso_oe", 32'(bus.miso_oe), 32'h0);
`endif
    wait_clk(2);
    rst_n = 1'b1;
    t0 = taken_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 11; i++) begin
      spi_bit(1'b1, b);
      check($sformatf("postrst_busy%0d", i), {bus.busy, b}, 32'h0);
    end
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    wait_clk(8);
    check("postrst_tx_taken", 32'(taken_cnt - t0), 32'd0);
    check("postrst_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("postrst_rx", {bus.rx_valid, 15'h0, bus.rx_data}, 32'h0);

    spi_frame(16'h3C3C, 32'hC3C3, 16, 0, got, v_end, b_mid, oe_mid);
    check("c3c3_miso", got, 32'h3C3C);
    check("c3c3_rx", {bus.rx_valid, bus.rx_overrun, 14'h0, bus.rx_data}, {1'b1, 1'b0, 14'h0, 16'hC3C3});

    // Acknowledge in the very cycle the next frame ends.
    spi_frame(16'h0000, 32'h5A5A, 16, 1, got, v_end, b_mid, oe_mid);
    check("ackend_valid_end", 32'(v_end), 32'h1);
    check("ackend_rx", {bus.rx_valid, bus.rx_overrun, 14'h0, bus.rx_data}, {1'b1, 1'b0, 14'h0, 16'h5A5A});
    pulse_ack();
    check("ack_clears_valid", 32'(bus.rx_valid), 32'h0);

    m_rx = 16'h5A5A; m_valid = 1'b0; m_ovr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      tx = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      word = $urandom & ((32'h1 << nb) - 1);
      ab = 1'($urandom_range(0, 1));
      ae = ($urandom_range(0, 3) == 0);
      exp_miso = '0;
      for (int i = 0; i < nb; i++) exp_miso = {exp_miso[30:0], (i < 16) ? tx[15 - i] : 1'b0};
      if (ab) m_valid = 1'b0;
      if (nb == 16) begin
        if (m_valid && !ae) m_ovr = 1'b1;
        m_rx = word[15:0];
        m_valid = 1'b1;
        e_ferr = 1'b0;
      end else begin
        e_ferr = 1'b1;
        if (ae) m_valid = 1'b0;
      end
      if (ab) pulse_ack();
      t0 = taken_cnt; f0 = ferr_cnt;
      spi_frame(tx, word, nb, ae, got, v_end, b_mid, oe_mid);
      check($sformatf("rnd%0d_miso", it), got, exp_miso);
      check($sformatf("rnd%0d_rx_data", it), 32'(bus.rx_data), 32'(m_rx));
      check($sformatf("rnd%0d_valid", it), {v_end, bus.rx_valid}, {m_valid, m_valid});
      check($sformatf("rnd%0d_overrun", it), 32'(bus.rx_overrun), 32'(m_ovr));
      check($sformatf("rnd%0d_frame_err", it), 32'(ferr_cnt - f0), 32'(e_ferr));
      check($sformatf("rnd%0d_tx_taken", it), 32'(taken_cnt - t0), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish within 3 ms");
    $fatal(1, "timeout");
  end
endmodule
